if_id_stall_register: RTL and testbench
=======================================

Name: if_id_stall_register

Overview:
- IF/ID pipeline register and stall/flush controller. It sits between fetch and decode, directly around the hazard detection unit.
- It feeds rsAddress_IfId/rtAddress_IfId to the hazard detection unit.
- It consumes that unit's hazard output and turns it into the PC write enable, the IF/ID hold, and a bubble request into ID/EX.
- It also counts stall cycles and flags a stall that lasts too long (watchdog).

Parameters:
- MAX_STALL, 3, maximum legal number of consecutive stall cycles before stallTimeout is raised (range 1..7).
- CNT_WIDTH, 16, width of the saturating total-stall counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- hazard  input  1  from hazard detection unit; 1 = instruction in ID must wait
- flush  input  1  taken branch/jump; discard instruction being fetched
- pcPlus4_If  input  32  PC+4 of instruction in fetch
- instruction_If  input  32  instruction word in fetch
- pcWrite  output  1  PC register enable (combinational)
- ifIdWrite  output  1  IF/ID register enable, exported for observation (combinational)
- bubble_IdEx  output  1  1 = ID/EX must load zero control (combinational)
- pcPlus4_IfId  output  32  registered PC+4
- instruction_IfId  output  32  registered instruction
- valid_IfId  output  1  registered; 0 = slot holds a NOP/bubble
- rsAddress_IfId  output  5  instruction_IfId[25:21] (combinational)
- rtAddress_IfId  output  5  instruction_IfId[20:16] (combinational)
- stallCycles  output  CNT_WIDTH  total stall cycles since reset, saturating
- stallTimeout  output  1  sticky watchdog flag

Behaviour:

Cycle classes (evaluated each cycle):
- FLUSH: flush=1, regardless of hazard. Flush wins over hazard.
- STALL: hazard=1 and flush=0.
- ADVANCE: otherwise.

Combinational outputs:
- pcWrite = ~STALL
- ifIdWrite = ~STALL
- bubble_IdEx = STALL

Register update at the rising edge, reset has highest priority:
- reset=1: pcPlus4_IfId=0, instruction_IfId=0, valid_IfId=0, stallCycles=0, stallTimeout=0, consecutive counter=0, state=RUN.
- FLUSH: instruction_IfId=32'h0 (NOP), pcPlus4_IfId=0, valid_IfId=0.
- STALL: all IF/ID fields hold.
- ADVANCE: load pcPlus4_If and instruction_If, valid_IfId=1.

While reset is asserted, pcWrite/ifIdWrite/bubble_IdEx still follow the combinational equations. Reset asserted mid-stall clears everything on that edge, including a set timeout. A NOP (all zero) yields rs=rt=0, so a flushed slot never causes a hazard.

Watchdog FSM (consecutive counter consec, 3 bits):
- RUN: STALL cycle -> go to STALL, consec=1. Otherwise stay in RUN, consec=0.
- STALL:
  - STALL cycle with consec<MAX_STALL -> consec+1.
  - STALL cycle with consec==MAX_STALL -> go to TIMEOUT, stallTimeout=1.
  - ADVANCE or FLUSH -> go to RUN, consec=0.
- TIMEOUT: terminal until reset. stallTimeout stays 1 and consec is frozen. Stall/flush/advance datapath behaviour is unchanged.
- The timeout therefore sets at the edge ending the (MAX_STALL+1)th consecutive stall cycle.
- A flush interrupting a stall run resets consec.

stallCycles:
- +1 at each edge ending a STALL cycle.
- Saturates at all-ones, no wrap.

Test Plan:
- Reset then ADVANCE with instruction_If=32'h012A4020, pcPlus4_If=32'h4 -> next cycle instruction_IfId=32'h012A4020, rsAddress_IfId=9, rtAddress_IfId=10, valid_IfId=1, pcWrite=1, bubble_IdEx=0.
- hazard=1 for 2 cycles with new fetch data applied -> IF/ID holds 32'h012A4020 both cycles, pcWrite=0, bubble_IdEx=1. Cycle 3 with hazard=0 loads the new fetch data. stallCycles=2, stallTimeout=0.
- hazard=1 and flush=1 in the same cycle -> pcWrite=1, bubble_IdEx=0. Next cycle instruction_IfId=0, valid_IfId=0, rs/rt=0, stallCycles unchanged.
- hazard=1 for 4 consecutive cycles (MAX_STALL=3) -> stallTimeout=0 after the 3rd edge, 1 after the 4th edge. It stays 1 after hazard drops, until reset.
- hazard for 3 cycles, flush for 1 cycle, hazard for 3 cycles -> stallTimeout remains 0, stallCycles=6.
- CNT_WIDTH=4, hazard held for 20 cycles -> stallCycles saturates at 15. Reset asserted mid-stall -> all registered outputs 0 on the next edge.

Source files
------------

// File: rtl/if_id_stall_register.sv
// IF/ID pipeline register with stall/flush control and a stall watchdog.
// Turns the hazard unit's request into PC/IF-ID enables and an ID/EX bubble,
// counts total stall cycles (saturating) and flags over-long stall runs.
module if_id_stall_register #(
  parameter int MAX_STALL = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hazard,
  input  logic                 flush,
  input  logic [31:0]          pcPlus4_If,
  input  logic [31:0]          instruction_If,
  output logic                 pcWrite,
  output logic                 ifIdWrite,
  output logic                 bubble_IdEx,
  output logic [31:0]          pcPlus4_IfId,
  output logic [31:0]          instruction_IfId,
  output logic                 valid_IfId,
  output logic [4:0]           rsAddress_IfId,
  output logic [4:0]           rtAddress_IfId,
  output logic [CNT_WIDTH-1:0] stallCycles,
  output logic                 stallTimeout
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [2:0] LP_MAX = 3'(MAX_STALL);
  localparam logic [CNT_WIDTH-1:0] LP_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Flush outranks hazard: a squashed fetch never holds the pipe.
  logic w_stall;
  assign w_stall = hazard & ~flush;

  assign pcWrite     = ~w_stall;
  assign ifIdWrite   = ~w_stall;
  assign bubble_IdEx = w_stall;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  // IF/ID slot: clear on flush (NOP, rs=rt=0 so no false hazard), hold on stall, else load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (!hazard) begin
      r_pc    <= pcPlus4_If;
      r_instr <= instruction_If;
      r_valid <= 1'b1;
    end
  end

  assign pcPlus4_IfId     = r_pc;
  assign instruction_IfId = r_instr;
  assign valid_IfId       = r_valid;
  assign rsAddress_IfId   = r_instr[25:21];
  assign rtAddress_IfId   = r_instr[20:16];

  state_t     r_state, w_state_nxt;
  logic [2:0] r_consec, w_consec_nxt;

  // Watchdog state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_consec <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_consec <= w_consec_nxt;
    end
  end

  // Watchdog next state: track the current run of back-to-back stalls; TIMEOUT is terminal.
  always_comb begin
    w_state_nxt  = r_state;
    w_consec_nxt = r_consec;
    case (r_state)
      ST_RUN: begin
        if (w_stall) begin
          w_state_nxt  = ST_STALL;
          w_consec_nxt = 3'd1;
        end else begin
          w_consec_nxt = 3'd0;
        end
      end
      ST_STALL: begin
        if (w_stall) begin
          if (r_consec < LP_MAX) w_consec_nxt = r_consec + 3'd1;
          else                   w_state_nxt  = ST_TIMEOUT;
        end else begin
          w_state_nxt  = ST_RUN;
          w_consec_nxt = 3'd0;
        end
      end
      ST_TIMEOUT: begin
        w_state_nxt = ST_TIMEOUT;
      end
      default: begin
        w_state_nxt  = ST_RUN;
        w_consec_nxt = 3'd0;
      end
    endcase
  end

  assign stallTimeout = (r_state == ST_TIMEOUT);

  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Total stall cycles, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset)                               r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + LP_ONE;
  end

  assign stallCycles = r_stall_cnt;

endmodule

// File: tb/tb_if_id_stall_register.sv
// Bench for if_id_stall_register: a run-length behavioural model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_if_id_stall_register;

  logic        clk = 1'b0;
  logic        reset, hazard, flush;
  logic [31:0] pcPlus4_If, instruction_If;

  logic        a_pcw, a_ifw, a_bub, a_vld, a_to;
  logic [31:0] a_pc, a_ins;
  logic [4:0]  a_rs, a_rt;
  logic [15:0] a_cnt;

  logic        b_pcw, b_ifw, b_bub, b_vld, b_to;
  logic [31:0] b_pc, b_ins;
  logic [4:0]  b_rs, b_rt;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stall_register #(.MAX_STALL(3), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .hazard(hazard), .flush(flush),
    .pcPlus4_If(pcPlus4_If), .instruction_If(instruction_If),
    .pcWrite(a_pcw), .ifIdWrite(a_ifw), .bubble_IdEx(a_bub),
    .pcPlus4_IfId(a_pc), .instruction_IfId(a_ins), .valid_IfId(a_vld),
    .rsAddress_IfId(a_rs), .rtAddress_IfId(a_rt),
    .stallCycles(a_cnt), .stallTimeout(a_to));

  if_id_stall_register #(.MAX_STALL(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .hazard(hazard), .flush(flush),
    .pcPlus4_If(pcPlus4_If), .instruction_If(instruction_If),
    .pcWrite(b_pcw), .ifIdWrite(b_ifw), .bubble_IdEx(b_bub),
    .pcPlus4_IfId(b_pc), .instruction_IfId(b_ins), .valid_IfId(b_vld),
    .rsAddress_IfId(b_rs), .rtAddress_IfId(b_rt),
    .stallCycles(b_cnt), .stallTimeout(b_to));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: slot contents, length of the current stall run, total stalls.
  bit          m_init = 0;
  logic [31:0] m_pc, m_ins;
  bit          m_vld, m_to;
  int          m_run, m_total;

  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1; m_pc <= 0; m_ins <= 0; m_vld <= 0;
      m_to <= 0; m_run <= 0; m_total <= 0;
    end else if (flush) begin
      m_pc <= 0; m_ins <= 0; m_vld <= 0; m_run <= 0;
    end else if (hazard) begin
      m_run   <= m_run + 1;
      m_total <= m_total + 1;
      if (m_run + 1 > 3) m_to <= 1;
    end else begin
      m_pc <= pcPlus4_If; m_ins <= instruction_If; m_vld <= 1; m_run <= 0;
    end
  end

  function automatic logic [31:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("a.pcWrite",   a_pcw, !(hazard && !flush));
      chk("a.ifIdWrite", a_ifw, !(hazard && !flush));
      chk("a.bubble",    a_bub, hazard && !flush);
      chk("a.pc",        a_pc,  m_pc);
      chk("a.ins",       a_ins, m_ins);
      chk("a.valid",     a_vld, m_vld);
      chk("a.rs",        a_rs,  m_ins[25:21]);
      chk("a.rt",        a_rt,  m_ins[20:16]);
      chk("a.cnt",       a_cnt, sat(m_total, 16));
      chk("a.timeout",   a_to,  m_to);
      chk("b.bubble",    b_bub, hazard && !flush);
      chk("b.pcWrite",   b_pcw, !(hazard && !flush));
      chk("b.ins",       b_ins, m_ins);
      chk("b.valid",     b_vld, m_vld);
      chk("b.cnt",       b_cnt, sat(m_total, 4));
      chk("b.timeout",   b_to,  m_to);
    end
  end

  task automatic drive(input logic h, input logic f, input logic [31:0] pc,
                       input logic [31:0] ins, input logic r);
    hazard = h; flush = f; pcPlus4_If = pc; instruction_If = ins; reset = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    tick(); tick();
    chk("lit.reset.valid", a_vld, 0);
    chk("lit.reset.ins",   a_ins, 0);
    chk("lit.reset.cnt",   a_cnt, 0);

    // Advance
    drive(0, 0, 32'h4, 32'h012A4020, 0);
    tick();
    chk("lit.adv.ins",   a_ins, 32'h012A4020);
    chk("lit.adv.pc",    a_pc,  32'h4);
    chk("lit.adv.rs",    a_rs,  9);
    chk("lit.adv.rt",    a_rt,  10);
    chk("lit.adv.valid", a_vld, 1);

    // Two stalls with new fetch data pending
    drive(1, 0, 32'h8, 32'h22222222, 0);
    chk("lit.stall.pcWrite", a_pcw, 0);
    chk("lit.stall.bubble",  a_bub, 1);
    tick();
    chk("lit.stall1.ins", a_ins, 32'h012A4020);
    tick();
    chk("lit.stall2.ins", a_ins, 32'h012A4020);
    chk("lit.stall2.cnt", a_cnt, 2);
    chk("lit.stall2.to",  a_to,  0);
    drive(0, 0, 32'h8, 32'h22222222, 0);
    tick();
    chk("lit.resume.ins", a_ins, 32'h22222222);
    chk("lit.resume.pc",  a_pc,  32'h8);

    // Flush wins over hazard
    drive(1, 1, 32'hC, 32'h33333333, 0);
    chk("lit.flush.pcWrite", a_pcw, 1);
    chk("lit.flush.bubble",  a_bub, 0);
    tick();
    chk("lit.flush.ins",   a_ins, 0);
    chk("lit.flush.valid", a_vld, 0);
    chk("lit.flush.rs",    a_rs,  0);
    chk("lit.flush.rt",    a_rt,  0);
    chk("lit.flush.cnt",   a_cnt, 2);

    // Four consecutive stalls trip the watchdog on the 4th edge
    drive(1, 0, 32'h10, 32'h44444444, 0);
    tick(); tick(); tick();
    chk("lit.wd3.to", a_to, 0);
    tick();
    chk("lit.wd4.to", a_to, 1);
    drive(0, 0, 32'h14, 32'h55555555, 0);
    tick(); tick();
    chk("lit.wd.sticky", a_to, 1);
    chk("lit.wd.ins",    a_ins, 32'h55555555);

    // Reset, then stall 3 / flush / stall 3: no timeout
    drive(0, 0, 0, 0, 1);
    tick();
    chk("lit.rst2.to", a_to, 0);
    drive(1, 0, 32'h20, 32'h01000000, 0);
    tick(); tick(); tick();
    drive(0, 1, 32'h24, 32'h02000000, 0);
    tick();
    drive(1, 0, 32'h28, 32'h03000000, 0);
    tick(); tick(); tick();
    drive(0, 0, 32'h2C, 32'h04000000, 0);
    tick();
    chk("lit.split.to",  a_to,  0);
    chk("lit.split.cnt", a_cnt, 6);
    chk("lit.split.cntb", b_cnt, 6);

    // 20 stalls: 4-bit counter saturates
    drive(1, 0, 32'h30, 32'h05000000, 0);
    repeat (20) tick();
    chk("lit.sat.cntb", b_cnt, 15);
    chk("lit.sat.cnta", a_cnt, 26);
    chk("lit.sat.to",   a_to,  1);

    // Reset mid-stall clears everything; combinational outputs still follow hazard
    drive(1, 0, 32'h30, 32'h05000000, 1);
    chk("lit.rststall.bubble", a_bub, 1);
    tick();
    chk("lit.rststall.ins",  a_ins, 0);
    chk("lit.rststall.pc",   a_pc,  0);
    chk("lit.rststall.vld",  a_vld, 0);
    chk("lit.rststall.cnt",  a_cnt, 0);
    chk("lit.rststall.cntb", b_cnt, 0);
    chk("lit.rststall.to",   a_to,  0);
    chk("lit.rststall.tob",  b_to,  0);

    drive(0, 0, 32'h40, 32'h06000000, 0);
    tick();
    chk("lit.end.ins", a_ins, 32'h06000000);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
